// File: rtl/block_memory_responder_pkg.sv
// Shared definitions for the cache refill/writeback path and its backing store.
// Address split of the default configuration: tag 3 / line 10 / offset 4.
package block_memory_responder_pkg;

    localparam int DATA_W          = 32;
    localparam int BLK_ADDR_W      = 13;
    localparam int WORDS_PER_BLOCK = 16;
    localparam int READ_LATENCY    = 4;
    localparam int OFFSET_W        = $clog2(WORDS_PER_BLOCK);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_BURST,
        WR_BURST,
        WR_DONE
    } state_e;

endpackage

// File: rtl/block_memory_responder_ram.sv
// Word array addressed by {block, offset}: one synchronous read port with a
// registered output that holds between reads, and one synchronous write port.
// Storage is split into one bank per word offset so that every bank can start
// out holding its own offset value (word j of every block reads back as j).
module block_ram_array #(
    parameter int DATA_W     = block_memory_responder_pkg::DATA_W,
    parameter int BLK_ADDR_W = block_memory_responder_pkg::BLK_ADDR_W,
    parameter int OFFSET_W   = block_memory_responder_pkg::OFFSET_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [BLK_ADDR_W-1:0] wr_blk_i,
    input  logic [OFFSET_W-1:0]   wr_off_i,
    input  logic [DATA_W-1:0]     wr_data_i,
    input  logic                  rd_en_i,
    input  logic [BLK_ADDR_W-1:0] rd_blk_i,
    input  logic [OFFSET_W-1:0]   rd_off_i,
    output logic [DATA_W-1:0]     rd_data_o
);

    localparam int WORDS  = 1 << OFFSET_W;
    localparam int BLOCKS = 1 << BLK_ADDR_W;

    logic [DATA_W-1:0] bank_rd [WORDS];
    logic [DATA_W-1:0] rd_data_q;

    for (genvar o = 0; o < WORDS; o++) begin : g_bank
        logic [DATA_W-1:0] bank_q [BLOCKS] = '{default: DATA_W'(o)};

        // Write the addressed block of this bank when the offset selects it.
        always_ff @(posedge clk_i) begin
            if (wr_en_i && (wr_off_i == OFFSET_W'(o))) begin
                bank_q[wr_blk_i] <= wr_data_i;
            end
        end

        assign bank_rd[o] = bank_q[rd_blk_i];
    end

    // Registered read data; only updated on a read so it holds otherwise.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= bank_rd[rd_off_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/block_memory_responder.sv
// Backing-store responder: accepts one block read or block write at a time.
// Reads stream a fixed-latency burst; writes accept a burst with gaps.
//
// state    | meaning
// IDLE     | ready for a request
// RD_WAIT  | read accepted, waiting out the access latency
// RD_BURST | issuing one word read per cycle, last cycle drains the final beat
// WR_BURST | taking write beats, gaps allowed
// WR_DONE  | write committed, wr_done pulse
module block_memory_responder #(
    parameter int DATA_W          = block_memory_responder_pkg::DATA_W,
    parameter int BLK_ADDR_W      = block_memory_responder_pkg::BLK_ADDR_W,
    parameter int WORDS_PER_BLOCK = block_memory_responder_pkg::WORDS_PER_BLOCK,
    parameter int READ_LATENCY    = block_memory_responder_pkg::READ_LATENCY
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [BLK_ADDR_W-1:0] req_block_addr_i,
    input  logic                  wdata_valid_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic                  rdata_valid_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic                  rdata_last_o,
    output logic                  wr_done_o
);

    import block_memory_responder_pkg::*;

    localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
    localparam int CNT_W = OFF_W + 1;
    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    state_e                state_q, state_d;
    logic [BLK_ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]      beat_q, beat_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic                  req_ready_q, rdata_valid_q, rdata_last_q, wr_done_q;
    logic                  rd_en, wr_en;

    // Next-state, counters and memory strobes.
    // The read burst spends one extra cycle after the last read so that the
    // final beat is still owned by RD_BURST; IDLE follows the rdata_last cycle.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        beat_d  = beat_q;
        lat_d   = lat_q;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    addr_d = req_block_addr_i;
                    beat_d = '0;
                    lat_d  = '0;
                    if (req_write_i) begin
                        state_d = WR_BURST;
                    end else if (READ_LATENCY == 1) begin
                        state_d = RD_BURST;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (lat_q == LAT_W'(READ_LATENCY - 2)) begin
                    state_d = RD_BURST;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            RD_BURST: begin
                if (beat_q == CNT_W'(WORDS_PER_BLOCK)) begin
                    state_d = IDLE;
                end else begin
                    rd_en  = 1'b1;
                    beat_d = beat_q + 1'b1;
                end
            end
            WR_BURST: begin
                if (wdata_valid_i) begin
                    wr_en  = 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == CNT_W'(WORDS_PER_BLOCK - 1)) begin
                        state_d = WR_DONE;
                    end
                end
            end
            WR_DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, request context and registered handshake outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            beat_q        <= '0;
            lat_q         <= '0;
            req_ready_q   <= 1'b1;
            rdata_valid_q <= 1'b0;
            rdata_last_q  <= 1'b0;
            wr_done_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            beat_q        <= beat_d;
            lat_q         <= lat_d;
            req_ready_q   <= (state_d == IDLE);
            rdata_valid_q <= rd_en;
            rdata_last_q  <= rd_en && (beat_q == CNT_W'(WORDS_PER_BLOCK - 1));
            wr_done_q     <= (state_d == WR_DONE);
        end
    end

    block_ram_array #(
        .DATA_W     (DATA_W),
        .BLK_ADDR_W (BLK_ADDR_W),
        .OFFSET_W   (OFF_W)
    ) u_ram (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (wr_en),
        .wr_blk_i  (addr_q),
        .wr_off_i  (beat_q[OFF_W-1:0]),
        .wr_data_i (wdata_i),
        .rd_en_i   (rd_en),
        .rd_blk_i  (addr_q),
        .rd_off_i  (beat_q[OFF_W-1:0]),
        .rd_data_o (rdata_o)
    );

    assign req_ready_o   = req_ready_q;
    assign rdata_valid_o = rdata_valid_q;
    assign rdata_last_o  = rdata_last_q;
    assign wr_done_o     = wr_done_q;

endmodule

// File: tb/tb_block_memory_responder.sv
// Bench for block_memory_responder: directed vector table, hand-written
// reset/back-to-back sequences, and random traffic against a memory model.
module tb_block_memory_responder;

    localparam int L = 4;
    localparam int W = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [12:0] req_addr;
    logic        wdata_valid;
    logic [31:0] wdata;
    logic        rdata_valid, rdata_last, wr_done;
    logic [31:0] rdata;

    int n_checks = 0;
    int n_err    = 0;

    // Reference memory: only words ever written are stored; others read as offset.
    logic [31:0] model [logic [16:0]];

    typedef struct {
        bit          wr;
        logic [12:0] blk;
        logic [31:0] base;      // write data start, or expected read start
        int          gap_after;
        int          gap_len;
    } vec_t;

    vec_t vecs [8];

    block_memory_responder dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_write_i      (req_write),
        .req_block_addr_i (req_addr),
        .wdata_valid_i    (wdata_valid),
        .wdata_i          (wdata),
        .rdata_valid_o    (rdata_valid),
        .rdata_o          (rdata),
        .rdata_last_o     (rdata_last),
        .wr_done_o        (wr_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%b required=%b", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [12:0] blk, input int off);
        logic [16:0] key;
        key = {blk, 4'(off)};
        return model.exists(key) ? model[key] : 32'(off);
    endfunction

    task automatic accept(input bit wr, input logic [12:0] blk);
        int n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chkb("accept_ready", req_ready, 1'b1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = blk;
        @(negedge clk);
        req_valid = 1'b0;
        chkb("accept_taken", req_ready, 1'b0);
    endtask

    task automatic write_body(input logic [12:0] blk, input logic [31:0] base, input bit rnd,
                              input int gap_after, input int gap_len, input bit rnd_gaps,
                              input int abort_at);
        logic [31:0] d;
        for (int i = 0; i < W; i++) begin
            d = rnd ? $urandom : base + 32'(i);
            wdata_valid = 1'b1;
            wdata       = d;
            if (i == abort_at) begin
                rst = 1'b1;
                #1;
                chkb("wr_abort_ready", req_ready, 1'b1);
                chkb("wr_abort_done", wr_done, 1'b0);
                @(negedge clk);
                rst = 1'b0;
                wdata_valid = 1'b0;
                return;
            end
            @(negedge clk);
            model[{blk, 4'(i)}] = d;
            if (i < W - 1) begin
                chkb("wr_done_early", wr_done, 1'b0);
                chkb("wr_ready_busy", req_ready, 1'b0);
                wdata_valid = 1'b0;
                if (i == gap_after) begin
                    repeat (gap_len) begin
                        wdata = $urandom;
                        @(negedge clk);
                        chkb("wr_done_gap", wr_done, 1'b0);
                    end
                end
                if (rnd_gaps && $urandom_range(0, 3) == 0) begin
                    wdata = ~d;
                    @(negedge clk);
                end
            end
        end
        wdata_valid = 1'b0;
        chkb("wr_done_pulse", wr_done, 1'b1);
        chkb("wr_done_ready", req_ready, 1'b0);
        @(negedge clk);
        chkb("wr_done_once", wr_done, 1'b0);
        chkb("wr_ready_after", req_ready, 1'b1);
    endtask

    task automatic do_read(input logic [12:0] blk, input bit use_exp, input logic [31:0] exp_base,
                           input bit noise, input int abort_at);
        logic [31:0] e;
        accept(1'b0, blk);
        chkb("rd_wait_valid", rdata_valid, 1'b0);
        for (int j = 1; j < L; j++) begin
            if (noise && j == 1) begin
                req_valid = 1'b1;
                req_write = 1'b1;
                req_addr  = 13'($urandom);
            end
            if (noise) begin
                wdata_valid = 1'b1;
                wdata       = $urandom;
            end
            @(negedge clk);
            req_valid = 1'b0;
            chkb("rd_wait_valid", rdata_valid, 1'b0);
            chkb("rd_wait_ready", req_ready, 1'b0);
        end
        for (int i = 0; i < W; i++) begin
            if (noise) begin
                wdata_valid = 1'($urandom_range(0, 1));
                wdata       = $urandom;
            end
            @(negedge clk);
            e = use_exp ? exp_base + 32'(i) : model_word(blk, i);
            chkb("rd_beat_valid", rdata_valid, 1'b1);
            chk("rd_beat_data", rdata, e);
            chkb("rd_beat_last", rdata_last, i == W - 1);
            chkb("rd_beat_ready", req_ready, 1'b0);
            if (i == abort_at) begin
                rst = 1'b1;
                #1;
                chkb("rd_abort_valid", rdata_valid, 1'b0);
                chkb("rd_abort_last", rdata_last, 1'b0);
                chkb("rd_abort_ready", req_ready, 1'b1);
                @(negedge clk);
                rst = 1'b0;
                wdata_valid = 1'b0;
                repeat (L + 2) begin
                    @(negedge clk);
                    chkb("rd_abort_quiet", rdata_valid, 1'b0);
                    chkb("rd_abort_idle", req_ready, 1'b1);
                end
                return;
            end
        end
        wdata_valid = 1'b0;
        @(negedge clk);
        chkb("rd_end_valid", rdata_valid, 1'b0);
        chkb("rd_end_last", rdata_last, 1'b0);
        chkb("rd_end_ready", req_ready, 1'b1);
        chk("rd_end_hold", rdata, e);
    endtask

    initial begin
        int          n, beat;
        bit          seen;
        logic [12:0] blk;
        logic [12:0] hot [4];

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        wdata_valid = 1'b0; wdata = '0;

        vecs[0] = '{wr: 1'b0, blk: 13'd0,    base: 32'h0,        gap_after: -1, gap_len: 0};
        vecs[1] = '{wr: 1'b1, blk: 13'd5,    base: 32'hA000,     gap_after: 7,  gap_len: 3};
        vecs[2] = '{wr: 1'b0, blk: 13'd5,    base: 32'hA000,     gap_after: -1, gap_len: 0};
        vecs[3] = '{wr: 1'b0, blk: 13'd4,    base: 32'h0,        gap_after: -1, gap_len: 0};
        vecs[4] = '{wr: 1'b1, blk: 13'd8191, base: 32'hFFFF0000, gap_after: -1, gap_len: 0};
        vecs[5] = '{wr: 1'b0, blk: 13'd8191, base: 32'hFFFF0000, gap_after: -1, gap_len: 0};
        vecs[6] = '{wr: 1'b0, blk: 13'd0,    base: 32'h0,        gap_after: -1, gap_len: 0};
        vecs[7] = '{wr: 1'b0, blk: 13'd8190, base: 32'h0,        gap_after: -1, gap_len: 0};

        repeat (2) @(negedge clk);
        chkb("rst_ready", req_ready, 1'b1);
        chkb("rst_valid", rdata_valid, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        chkb("rst_last", rdata_last, 1'b0);
        chkb("rst_wr_done", wr_done, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].wr) begin
                accept(1'b1, vecs[v].blk);
                write_body(vecs[v].blk, vecs[v].base, 1'b0, vecs[v].gap_after, vecs[v].gap_len, 1'b0, -1);
            end else begin
                do_read(vecs[v].blk, 1'b1, vecs[v].base, 1'b0, -1);
            end
        end

        // Reset during read beat 6, then during write beat 9
        do_read(13'd0, 1'b0, 32'h0, 1'b0, 6);
        accept(1'b1, 13'd5);
        write_body(13'd5, 32'hB000, 1'b0, -1, 0, 1'b0, 9);
        do_read(13'd5, 1'b0, 32'h0, 1'b0, -1);
        chk("partial_model_w8", model_word(13'd5, 8), 32'hB008);
        chk("partial_model_w9", model_word(13'd5, 9), 32'hA009);

        // Back-to-back: read block 2 with req_valid held, then write block 3
        req_valid = 1'b1; req_write = 1'b0; req_addr = 13'd2;
        @(negedge clk);
        chkb("b2b_first_taken", req_ready, 1'b0);
        req_write = 1'b1; req_addr = 13'd3;
        wdata_valid = 1'b1;
        seen = 1'b0; n = 0; beat = 0;
        while (!seen && n < 60) begin
            wdata = $urandom;
            @(negedge clk);
            n++;
            if (rdata_valid) begin
                chk("b2b_rdata", rdata, model_word(13'd2, beat));
                beat++;
                if (rdata_last) seen = 1'b1;
            end
        end
        chkb("b2b_last_seen", seen, 1'b1);
        chk("b2b_beats", 32'(beat), 32'(W));
        wdata_valid = 1'b0;
        @(negedge clk);
        chkb("b2b_idle_ready", req_ready, 1'b1);
        @(negedge clk);
        chkb("b2b_second_taken", req_ready, 1'b0);
        req_valid = 1'b0;
        write_body(13'd3, 32'hC000, 1'b0, -1, 0, 1'b0, -1);
        do_read(13'd3, 1'b1, 32'hC000, 1'b0, -1);
        do_read(13'd2, 1'b1, 32'h0, 1'b0, -1);

        // Request pulse and write beats while a read is in flight are ignored
        do_read(13'd7, 1'b0, 32'h0, 1'b1, -1);

        // Random traffic against the model
        hot[0] = 13'd5; hot[1] = 13'd6; hot[2] = 13'd7; hot[3] = 13'd8191;
        for (int t = 0; t < 40; t++) begin
            blk = ($urandom_range(0, 3) == 0) ? 13'($urandom) : hot[$urandom_range(0, 3)];
            if ($urandom_range(0, 1) == 1) begin
                accept(1'b1, blk);
                write_body(blk, 32'h0, 1'b1, -1, 0, 1'b1, -1);
            end else begin
                do_read(blk, 1'b0, 32'h0, 1'($urandom_range(0, 1)), -1);
            end
        end
        do_read(13'd0, 1'b1, 32'h0, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
